// File: rtl/cordic_vector_iter.sv
// cordic_vector_iter: iterative CORDIC vectoring, (X, Y) -> (atan2 angle, K*|v| magnitude).
// Latency: accept edge + ITER micro-rotation edges, so the result is valid after ITER+1 edges.
// Backpressure: in_ready only while idle; the result holds in DONE until out_ready.
module cordic_vector_iter #(
  parameter int DSIZE = 16,
  parameter int ITER  = 12,
  parameter int ASIZE = 16
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DSIZE-1:0] X,
  input  logic signed [DSIZE-1:0] Y,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ASIZE-1:0] angle,
  output logic        [DSIZE:0]   magnitude
);

  // Two guard bits: one for negating the most negative input, one for CORDIC gain.
  localparam int XW  = DSIZE + 2;
  localparam int IW  = 5;
  // Right shift that turns a 32-bit (pi = 2^31) table entry into ASIZE-bit angle units.
  localparam int RSH = 32 - ASIZE;

  typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic signed [XW-1:0]  r_x;
  logic signed [XW-1:0]  r_y;
  logic [ASIZE-1:0]      r_z;
  logic [IW-1:0]         r_i;
  logic                  r_zero;

  logic signed [XW-1:0]  w_x_ext;
  logic signed [XW-1:0]  w_y_ext;
  logic signed [XW-1:0]  w_xs;
  logic signed [XW-1:0]  w_ys;
  logic [ASIZE-1:0]      w_atan;
  logic                  w_y_neg;
  logic                  w_accept;

  // atan(2^-i) with pi represented as 2^31.
  function automatic logic [31:0] atan32(input logic [IW-1:0] idx);
    case (idx)
      5'd0:    return 32'd536870912;
      5'd1:    return 32'd316933406;
      5'd2:    return 32'd167458907;
      5'd3:    return 32'd85004756;
      5'd4:    return 32'd42667331;
      5'd5:    return 32'd21354465;
      5'd6:    return 32'd10679838;
      5'd7:    return 32'd5340245;
      5'd8:    return 32'd2670163;
      5'd9:    return 32'd1335087;
      5'd10:   return 32'd667544;
      5'd11:   return 32'd333772;
      5'd12:   return 32'd166886;
      5'd13:   return 32'd83443;
      5'd14:   return 32'd41722;
      5'd15:   return 32'd20861;
      default: return 32'd0;
    endcase
  endfunction

  // Round-half-up reduction to ASIZE bits; doubling first keeps RSH = 0 well-defined.
  function automatic logic [ASIZE-1:0] atan_entry(input logic [IW-1:0] idx);
    logic [33:0] t;
    t = {1'b0, atan32(idx), 1'b0} + (34'd1 << RSH);
    t = t >> (RSH + 1);
    return t[ASIZE-1:0];
  endfunction

  assign w_x_ext  = {{2{X[DSIZE-1]}}, X};
  assign w_y_ext  = {{2{Y[DSIZE-1]}}, Y};
  assign w_xs     = r_x >>> r_i;
  assign w_ys     = r_y >>> r_i;
  assign w_atan   = atan_entry(r_i);
  assign w_y_neg  = r_y[XW-1];
  assign w_accept = (r_state == ST_IDLE) && in_valid;

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_ITER;
      end
      ST_ITER: begin
        if (r_i == IW'(ITER - 1)) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: quadrant pre-rotation on accept, then one micro-rotation per cycle.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_i    <= '0;
      r_zero <= 1'b0;
    end else if (w_accept) begin
      r_i    <= '0;
      r_zero <= (X == '0) && (Y == '0);
      if (X[DSIZE-1]) begin
        // Left half-plane: rotate by pi so the iterations only cover +-pi/2.
        r_x <= -w_x_ext;
        r_y <= -w_y_ext;
        r_z <= {1'b1, {(ASIZE-1){1'b0}}};
      end else begin
        r_x <= w_x_ext;
        r_y <= w_y_ext;
        r_z <= '0;
      end
    end else if (r_state == ST_ITER) begin
      if (w_y_neg) begin
        r_x <= r_x - w_ys;
        r_y <= r_y + w_xs;
        r_z <= r_z - w_atan;
      end else begin
        r_x <= r_x + w_ys;
        r_y <= r_y - w_xs;
        r_z <= r_z + w_atan;
      end
      r_i <= r_i + 1'b1;
    end
  end

  // Result is only driven in DONE; a zero input forces a clean zero result.
  always_comb begin
    angle     = '0;
    magnitude = '0;
    if ((r_state == ST_DONE) && !r_zero) begin
      angle     = r_z;
      magnitude = r_x[DSIZE:0];
    end
  end

endmodule

// File: tb/tb_cordic_vector_iter.sv
// tb_cordic_vector_iter: directed vectors for the iterative CORDIC vectoring engine.
// Latency: expects the result after the 13th edge counting the accept edge (ITER=12).
// Backpressure: holds out_ready low in DONE and checks stability and input blocking.
module tb_cordic_vector_iter;

  logic               clock;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] X;
  logic signed [15:0] Y;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] angle;
  logic [16:0]        magnitude;

  int n_chk  = 0;
  int n_pass = 0;

  cordic_vector_iter #(.DSIZE(16), .ITER(12), .ASIZE(16)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .angle     (angle),
    .magnitude (magnitude)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input longint obs, input longint exp,
                       input longint tol = 0);
    longint d;
    n_chk++;
    d = (obs > exp) ? obs - exp : exp - obs;
    if (d <= tol) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
  endtask

  // Angle observed, re-expressed as the value nearest e modulo 2^16.
  function automatic longint unwrap(input logic [15:0] a, input longint e);
    logic [15:0] d;
    d = a - 16'(e);
    return e + longint'($signed(d));
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Present a sample and return just after the edge that accepts it.
  task automatic send(input int x, input int y);
    int n;
    X        = 16'(x);
    Y        = 16'(y);
    in_valid = 1'b1;
    n        = 0;
    while (!in_ready && n < 50) begin
      tick;
      n++;
    end
    tick;
    in_valid = 1'b0;
  endtask

  // Edges counted from the accept edge (inclusive) until out_valid is seen.
  task automatic wait_out(output int edges);
    edges = 1;
    while (!out_valid && edges < 40) begin
      tick;
      edges++;
    end
  endtask

  task automatic do_vec(input string tag, input int x, input int y,
                        input longint ea, input longint ta,
                        input longint em, input longint tm);
    int lat;
    send(x, y);
    wait_out(lat);
    check({tag, "_lat"}, lat, 13);
    check({tag, "_ang"}, unwrap(angle, ea), ea, ta);
    check({tag, "_mag"}, magnitude, em, tm);
    tick;
    check({tag, "_pulse"}, out_valid, 0);
  endtask

  initial begin
    int lat;
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    X         = '0;
    Y         = '0;
    repeat (3) tick;
    rst_n = 1'b1;
    tick;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_angle", angle, 0);
    check("rst_mag", magnitude, 0);

    // Exact values traced by hand through the 12 micro-rotations.
    do_vec("x1000",     1000,   0,      7, 0,  1649, 0);
    do_vec("neg_pi_lo", -1000, -1, -32751, 0,  1650, 0);
    do_vec("neg_pi_hi", -1000,  1,  32761, 0,  1647, 0);
    // Accuracy-bounded cases.
    do_vec("diag",       1000,  1000,   8192, 32,  2329, 16);
    do_vec("down",          0, -1000, -16384, 32,  1647, 16);
    do_vec("left",      -1000,     0, -32768, 32,  1647, 16);
    do_vec("min_xy",   -32768, -32768, -24576, 32, 76315, 16);
    do_vec("zero",          0,     0,      0,  0,     0,  0);

    // Backpressure: result held for 5 cycles while a second sample waits.
    out_ready = 1'b0;
    send(1000, 0);
    wait_out(lat);
    check("bp_lat", lat, 13);
    X        = -16'sd1000;
    Y        = -16'sd1;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      check("bp_hold_vld", out_valid, 1);
      check("bp_hold_ang", angle, 7);
      check("bp_hold_mag", magnitude, 1649);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick;
    check("bp_release_vld", out_valid, 0);
    check("bp_release_rdy", in_ready, 1);
    tick;
    in_valid = 1'b0;
    wait_out(lat);
    check("bp2_lat", lat, 13);
    check("bp2_ang", unwrap(angle, -32751), -32751);
    check("bp2_mag", magnitude, 1650);
    tick;

    // Reset in the middle of the iterations discards the sample.
    send(1000, 1000);
    repeat (6) tick;
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", out_valid, 0);
    check("mid_rst_ang", angle, 0);
    check("mid_rst_mag", magnitude, 0);
    check("mid_rst_rdy", in_ready, 1);
    tick;
    rst_n = 1'b1;
    seen  = 0;
    for (int k = 0; k < 20; k++) begin
      tick;
      if (out_valid) seen++;
    end
    check("mid_rst_stale", seen, 0);
    do_vec("post_rst", -1000, 1, 32761, 0, 1647, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
